// File: rtl/ahblite_spi_slave_pkg.sv
// Shared definitions for the AHB-Lite SPI slave: register map, bit positions,
// serial FSM state type and the idle fill pattern.
package ahblite_spi_slave_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned STAT_RXNE   = 0;
    localparam int unsigned STAT_RXFULL = 1;
    localparam int unsigned STAT_TXEMP  = 2;
    localparam int unsigned STAT_RXOVF  = 3;
    localparam int unsigned STAT_CSACT  = 4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_RXIE = 1;
    localparam int unsigned CTRL_TXIE = 2;

    localparam logic [7:0] IDLE_FILL = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Byte presented to the master on a TX load: holding data, or idle fill when nothing is queued.
    function automatic logic [7:0] tx_load_value(input logic empty, input logic [7:0] hold);
        logic [7:0] val;
        if (empty) begin
            val = IDLE_FILL;
        end else begin
            val = hold;
        end
        return val;
    endfunction

endpackage

// File: rtl/ahblite_spi_slave_if.sv
// AHB-Lite slave-side bus bundle for the SPI slave peripheral.
interface ahblite_spi_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous byte FIFO for received SPI data; a push on a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module spi_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_r[rptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= din;
                wptr_r        <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/ahblite_spi_slave.sv
// AHB-Lite mapped SPI mode-0 slave: register file, synchronized SPI front end,
// IDLE/ACTIVE serial FSM with TX holding register and an RX FIFO.
module ahblite_spi_slave
    import ahblite_spi_slave_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahblite_spi_slave_if.slave  ahb,
    input  logic                SPI_CS,
    input  logic                SPI_CLK,
    input  logic                SPI_MOSI,
    output logic                SPI_MISO,
    output logic                SPI_MISO_OE,
    output logic                spi_irq
);
    spi_state_e  state_r, state_nxt_s;
    logic [1:0]  cs_sync_r, sclk_sync_r, mosi_sync_r;
    logic        cs_prev_r, sclk_prev_r;
    logic        cs_s, sclk_s, mosi_s;
    logic        cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic        dp_valid_r, dp_write_r;
    logic [1:0]  dp_addr_r;
    logic [2:0]  ctrl_r;
    logic [7:0]  tx_hold_r, tx_shift_r, rx_shift_r;
    logic        tx_empty_r, rx_ovf_r;
    logic [2:0]  bit_cnt_r;
    logic        en_s, start_s, stay_s, rx_edge_s, tx_edge_s, load_s;
    logic        push_req_s, push_s, ovf_set_s;
    logic        wr_data_s, wr_status_s, wr_ctrl_s, rd_data_s, pop_s;
    logic [7:0]  push_byte_s, fifo_dout_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [31:0] status_s, rdata_s;
    logic        unused_s;

    assign unused_s = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HSIZE, ahb.HPROT,
                        ahb.HTRANS[0], ahb.HWDATA[31:8]};

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cs_sync_r   <= 2'b11;
            sclk_sync_r <= 2'b00;
            mosi_sync_r <= 2'b00;
            cs_prev_r   <= 1'b1;
            sclk_prev_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], SPI_CS};
            sclk_sync_r <= {sclk_sync_r[0], SPI_CLK};
            mosi_sync_r <= {mosi_sync_r[0], SPI_MOSI};
            cs_prev_r   <= cs_sync_r[1];
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    assign cs_s        = cs_sync_r[1];
    assign sclk_s      = sclk_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];
    assign cs_fall_s   = cs_prev_r & ~cs_s;
    assign cs_rise_s   = ~cs_prev_r & cs_s;
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign en_s        = ctrl_r[CTRL_EN];

    // Serial FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and per-cycle serial event decode; edges count only while the frame stays open.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        stay_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s && en_s) begin
                    state_nxt_s = ST_ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s || !en_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                    stay_s      = 1'b1;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign rx_edge_s   = stay_s & sclk_rise_s;
    assign tx_edge_s   = stay_s & sclk_fall_s;
    assign load_s      = start_s | (tx_edge_s & (bit_cnt_r == 3'd0));
    assign push_req_s  = rx_edge_s & (bit_cnt_r == 3'd7);
    assign push_byte_s = {rx_shift_r[6:0], mosi_s};
    assign push_s      = push_req_s & (~fifo_full_s | pop_s);
    assign ovf_set_s   = push_req_s & fifo_full_s & ~pop_s;

    // Shift registers and bit counter; leaving ACTIVE drops any partial byte.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
            tx_shift_r <= IDLE_FILL;
        end else if (start_s) begin
            bit_cnt_r  <= 3'd0;
            tx_shift_r <= tx_load_value(tx_empty_r, tx_hold_r);
        end else if (!stay_s) begin
            bit_cnt_r <= 3'd0;
        end else begin
            if (rx_edge_s) begin
                rx_shift_r <= push_byte_s;
                bit_cnt_r  <= bit_cnt_r + 3'd1;
            end
            if (tx_edge_s) begin
                if (bit_cnt_r == 3'd0) begin
                    tx_shift_r <= tx_load_value(tx_empty_r, tx_hold_r);
                end else begin
                    tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                end
            end
        end
    end

    // AHB address phase capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_addr_r  <= 2'd0;
        end else begin
            dp_valid_r <= ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
            dp_write_r <= ahb.HWRITE;
            dp_addr_r  <= ahb.HADDR[3:2];
        end
    end

    assign wr_data_s   = dp_valid_r & dp_write_r & (dp_addr_r == REG_DATA);
    assign wr_status_s = dp_valid_r & dp_write_r & (dp_addr_r == REG_STATUS);
    assign wr_ctrl_s   = dp_valid_r & dp_write_r & (dp_addr_r == REG_CTRL);
    assign rd_data_s   = dp_valid_r & ~dp_write_r & (dp_addr_r == REG_DATA);
    assign pop_s       = rd_data_s & ~fifo_empty_s;

    // Control, TX holding and sticky status; a DATA write beats a same-cycle TX load for tx_empty.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_r     <= 3'b000;
            tx_hold_r  <= 8'h00;
            tx_empty_r <= 1'b1;
            rx_ovf_r   <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_r <= ahb.HWDATA[2:0];
            end
            if (wr_data_s) begin
                tx_hold_r  <= ahb.HWDATA[7:0];
                tx_empty_r <= 1'b0;
            end else if (load_s) begin
                tx_empty_r <= 1'b1;
            end
            if (ovf_set_s) begin
                rx_ovf_r <= 1'b1;
            end else if (wr_status_s && ahb.HWDATA[STAT_RXOVF]) begin
                rx_ovf_r <= 1'b0;
            end
        end
    end

    spi_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push_s),
        .din   (push_byte_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Status word and data-phase read mux.
    always_comb begin
        status_s              = 32'h0000_0000;
        status_s[STAT_RXNE]   = ~fifo_empty_s;
        status_s[STAT_RXFULL] = fifo_full_s;
        status_s[STAT_TXEMP]  = tx_empty_r;
        status_s[STAT_RXOVF]  = rx_ovf_r;
        status_s[STAT_CSACT]  = ~cs_s;
        rdata_s               = 32'h0000_0000;
        if (dp_valid_r && !dp_write_r) begin
            case (dp_addr_r)
                REG_DATA: begin
                    if (fifo_empty_s) begin
                        rdata_s = 32'h0000_0000;
                    end else begin
                        rdata_s = {24'h00_0000, fifo_dout_s};
                    end
                end
                REG_STATUS: rdata_s = status_s;
                REG_CTRL:   rdata_s = {29'h0000_0000, ctrl_r};
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign ahb.HRDATA  = rdata_s;
    assign SPI_MISO    = tx_shift_r[7];
    assign SPI_MISO_OE = (state_r == ST_ACTIVE);
    assign spi_irq     = (ctrl_r[CTRL_RXIE] & (~fifo_empty_s | rx_ovf_r))
                       | (ctrl_r[CTRL_TXIE] & en_s & tx_empty_r);
endmodule

// File: tb/tb_ahblite_spi_slave.sv
// Directed bench: drives AHB register accesses and a bit-banged SPI mode-0 master.
module tb_ahblite_spi_slave;
    logic HCLK;
    logic HRESETn;
    logic SPI_CS, SPI_CLK, SPI_MOSI;
    logic SPI_MISO, SPI_MISO_OE, spi_irq;
    int   vec_cnt;
    int   err_cnt;
    logic [31:0] rd;
    logic [7:0]  miso;

    ahblite_spi_slave_if bus ();

    ahblite_spi_slave #(.RX_DEPTH(4)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .ahb         (bus),
        .SPI_CS      (SPI_CS),
        .SPI_CLK     (SPI_CLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .spi_irq     (spi_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = 1'b1;
        wait_clk(1);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = data;
        wait_clk(1);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = 1'b0;
        wait_clk(1);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        data = bus.HRDATA;
        wait_clk(1);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = tx[7-i];
            wait_clk(8);
            rx = {rx[6:0], SPI_MISO};
            SPI_CLK = 1'b1;
            wait_clk(8);
            SPI_CLK = 1'b0;
        end
        wait_clk(8);
    endtask

    task automatic cs_set(input logic level);
        SPI_CS = level;
        wait_clk(8);
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        HRESETn = 1'b0;
        SPI_CS = 1'b1; SPI_CLK = 1'b0; SPI_MOSI = 1'b0;
        bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
        bus.HPROT = 4'b0011; bus.HWRITE = 1'b0; bus.HWDATA = 32'h0; bus.HREADY = 1'b1;
        wait_clk(4);
        check_val("rst_miso", {31'h0, SPI_MISO}, 32'h1);
        check_val("rst_oe", {31'h0, SPI_MISO_OE}, 32'h0);
        check_val("rst_irq", {31'h0, spi_irq}, 32'h0);
        check_val("rst_hrdata", bus.HRDATA, 32'h0);
        check_val("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        check_val("hresp", {31'h0, bus.HRESP}, 32'h0);
        HRESETn = 1'b1;
        wait_clk(2);
        ahb_read(32'h4, rd); check_val("rst_status", rd, 32'h04);
        ahb_read(32'h8, rd); check_val("rst_ctrl", rd, 32'h00);

        // Basic exchange: TX 0xA5 out, 0x3C in.
        ahb_write(32'h8, 32'h1);
        ahb_write(32'h0, 32'hA5);
        ahb_read(32'h8, rd); check_val("ctrl_rb", rd, 32'h01);
        ahb_read(32'hC, rd); check_val("reg3_zero", rd, 32'h0);
        cs_set(1'b0);
        spi_xfer(8'h3C, 8, miso);
        check_val("a5_miso", {24'h0, miso}, 32'hA5);
        check_val("a5_oe", {31'h0, SPI_MISO_OE}, 32'h1);
        cs_set(1'b1);
        check_val("a5_oe_off", {31'h0, SPI_MISO_OE}, 32'h0);
        ahb_read(32'h4, rd); check_val("a5_stat_ne", rd, 32'h05);
        ahb_read(32'h0, rd); check_val("a5_data", rd, 32'h3C);
        ahb_read(32'h4, rd); check_val("a5_stat_e", rd, 32'h04);
        ahb_read(32'h0, rd); check_val("empty_read", rd, 32'h00);
        ahb_read(32'h4, rd); check_val("empty_stat", rd, 32'h04);

        // Overflow: five bytes into a four-deep FIFO.
        cs_set(1'b0);
        for (int b = 1; b <= 5; b++) begin
            spi_xfer(8'(b), 8, miso);
            check_val("ovf_miso_fill", {24'h0, miso}, 32'hFF);
        end
        cs_set(1'b1);
        ahb_read(32'h4, rd); check_val("ovf_stat", rd, 32'h0F);
        for (int b = 1; b <= 4; b++) begin
            ahb_read(32'h0, rd); check_val("ovf_data", rd, 32'(b));
        end
        ahb_read(32'h4, rd); check_val("ovf_sticky", rd, 32'h0C);
        ahb_write(32'h4, 32'h8);
        ahb_read(32'h4, rd); check_val("ovf_clear", rd, 32'h04);

        // Two-byte frame, single TX write.
        ahb_write(32'h0, 32'h5A);
        cs_set(1'b0);
        ahb_read(32'h4, rd); check_val("two_stat_load", rd, 32'h14);
        spi_xfer(8'h11, 8, miso); check_val("two_miso0", {24'h0, miso}, 32'h5A);
        spi_xfer(8'h22, 8, miso); check_val("two_miso1", {24'h0, miso}, 32'hFF);
        cs_set(1'b1);
        ahb_read(32'h0, rd); check_val("two_rx0", rd, 32'h11);
        ahb_read(32'h0, rd); check_val("two_rx1", rd, 32'h22);

        // Partial byte discarded by CS deassertion.
        cs_set(1'b0);
        spi_xfer(8'hF8, 5, miso);
        cs_set(1'b1);
        check_val("part_oe_off", {31'h0, SPI_MISO_OE}, 32'h0);
        ahb_read(32'h4, rd); check_val("part_stat", rd, 32'h04);
        cs_set(1'b0);
        spi_xfer(8'h81, 8, miso);
        cs_set(1'b1);
        ahb_read(32'h0, rd); check_val("part_rx", rd, 32'h81);
        ahb_read(32'h4, rd); check_val("part_only", rd, 32'h04);

        // Interrupts.
        ahb_write(32'h8, 32'h3);
        check_val("irq_idle", {31'h0, spi_irq}, 32'h0);
        cs_set(1'b0);
        spi_xfer(8'h77, 8, miso);
        cs_set(1'b1);
        check_val("irq_rx", {31'h0, spi_irq}, 32'h1);
        ahb_read(32'h0, rd); check_val("irq_data", rd, 32'h77);
        check_val("irq_rx_clr", {31'h0, spi_irq}, 32'h0);
        ahb_write(32'h8, 32'h5);
        check_val("irq_tx", {31'h0, spi_irq}, 32'h1);
        ahb_write(32'h0, 32'h33);
        check_val("irq_tx_clr", {31'h0, spi_irq}, 32'h0);

        // Reset pulse in the middle of a frame.
        ahb_write(32'h8, 32'h7);
        cs_set(1'b0);
        spi_xfer(8'h00, 4, miso);
        check_val("mid_miso", {24'h0, miso}, 32'h03);
        check_val("mid_irq", {31'h0, spi_irq}, 32'h1);
        check_val("mid_oe", {31'h0, SPI_MISO_OE}, 32'h1);
        HRESETn = 1'b0;
        #2;
        check_val("rr_miso", {31'h0, SPI_MISO}, 32'h1);
        check_val("rr_oe", {31'h0, SPI_MISO_OE}, 32'h0);
        check_val("rr_irq", {31'h0, spi_irq}, 32'h0);
        check_val("rr_hrdata", bus.HRDATA, 32'h0);
        wait_clk(3);
        SPI_CS = 1'b1;
        wait_clk(3);
        HRESETn = 1'b1;
        wait_clk(2);
        ahb_read(32'h4, rd); check_val("rr_status", rd, 32'h04);
        ahb_read(32'h8, rd); check_val("rr_ctrl", rd, 32'h00);
        check_val("rr_miso_after", {31'h0, SPI_MISO}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ahblite_spi_slave.md
AHBLITE_SPI_SLAVE -- requirements
Module: ahblite_spi_slave

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth in bytes; power of two, range 2..16.
REQ-002 SHALL have port HCLK, input, 1, system clock.
REQ-003 SHALL have port HRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have AHB-Lite slave ports with standard widths and meanings: HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0] and HREADY as inputs; HREADYOUT, HRDATA[31:0] and HRESP as outputs.
REQ-005 SHALL have ports SPI_CS (input, 1, chip select from the external master, active-low), SPI_CLK (input, 1, serial clock), SPI_MOSI (input, 1, data from the master), SPI_MISO (output, 1, data to the master) and SPI_MISO_OE (output, 1, MISO drive enable).
REQ-006 SHALL have port spi_irq, output, 1, level interrupt.

Function
REQ-007 HREADYOUT SHALL be constant 1 and HRESP constant 0 (zero-wait, OKAY).
REQ-008 Address phase, qualified by HSEL & HREADY & HTRANS[1], SHALL register HADDR[3:2] and HWRITE; register actions occur in the following data phase.
REQ-009 Register map by HADDR[3:2]:
- 0 DATA: read pops one RX byte into HRDATA[7:0]; write loads HWDATA[7:0] into TX holding register.
- 1 STATUS (RO except bit3): bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 rx_ovf (sticky, write 1 to clear), bit4 cs_active.
- 2 CTRL (RW): bit0 en, bit1 rxie, bit2 txie.
- 3: reads 0, writes ignored.
- All unused bits read 0.
REQ-010 Reading DATA while the FIFO is empty SHALL return 0 with no pointer change.
REQ-011 SPI_CS, SPI_CLK and SPI_MOSI SHALL pass through 2-flop synchronizers; edges are detected on the synchronized signals; HCLK >= 8x SPI_CLK is required.
REQ-012 Protocol SHALL be SPI mode 0, MSB first, 8-bit frames.
REQ-013 FSM states SHALL be IDLE and ACTIVE.
- IDLE->ACTIVE: synchronized CS falling with en=1; bit_cnt <= 0; tx_shift <= TX holding (0xFF if tx_empty); tx_empty <= 1.
- ACTIVE->IDLE: synchronized CS rising, or en=0.
REQ-014 In ACTIVE, each synchronized SCLK rising edge SHALL shift MOSI into rx_shift LSB and increment the 3-bit bit_cnt, wrapping 7->0.
REQ-015 On the rising edge that wraps bit_cnt to 0, the assembled byte SHALL be pushed to the FIFO.
- If the FIFO is full and no pop occurs that cycle: byte dropped, rx_ovf <= 1.
- Push and pop in the same cycle on a full FIFO SHALL succeed with no overflow.
REQ-016 In ACTIVE, each synchronized SCLK falling edge SHALL act as follows:
- bit_cnt != 0: shift tx_shift left.
- bit_cnt == 0: reload tx_shift from TX holding (0xFF if empty) and set tx_empty.
REQ-017 SPI_MISO SHALL equal tx_shift[7]; SPI_MISO_OE SHALL be 1 only in ACTIVE.
REQ-018 CS deasserted mid-byte SHALL discard the partial byte with no push and no overflow, and clear bit_cnt.
REQ-019 An AHB DATA write in the same cycle as a TX load SHALL let the load take the old value, then hold the new value with tx_empty=0.
REQ-020 Writing DATA while tx_empty=0 SHALL overwrite the holding register.
REQ-021 spi_irq SHALL equal (rxie & (rx_not_empty | rx_ovf)) | (txie & en & tx_empty), combinational from registered state.
REQ-022 With en=0, SPI edges SHALL be ignored; FIFO and TX holding contents are retained.

Reset
REQ-023 HRESETn low SHALL asynchronously force:
- FSM to IDLE; FIFO empty; rx_ovf=0; tx_empty=1; TX holding=0x00.
- tx_shift=0xFF; bit_cnt=0; CTRL=0; synchronizers to CS=1, CLK=0, MOSI=0.
- Outputs: SPI_MISO=1, SPI_MISO_OE=0, spi_irq=0, HRDATA=0.

Structure
REQ-024 A shared package SHALL hold the register offsets, STATUS/CTRL bit positions, the FSM state type and the 0xFF idle-fill constant.
REQ-025 The RX FIFO SHALL be sub-module spi_rx_fifo (synchronous, push/pop/full/empty); all other logic resides in ahblite_spi_slave.

Verification
REQ-026 Bench SHALL cover:
- CTRL=0x1, TX=0xA5, master sends 0x3C -> MISO shifts 0xA5; DATA reads 0x3C; STATUS bit0 then 0.
- Five bytes 0x01..0x05 sent with no reads, RX_DEPTH=4 -> reads return 0x01..0x04; rx_ovf=1; writing STATUS=0x8 clears it.
- Two-byte frame with only one TX write 0x5A -> MISO 0x5A then 0xFF; tx_empty=1 after first load.
- CS raised after 5 bits, then full byte 0x81 -> FIFO holds only 0x81; MISO_OE low between frames.
- CTRL=0x3, one byte received -> spi_irq rises; DATA read -> spi_irq falls; HRESETn pulse mid-frame -> all REQ-023 values hold.
